// File: rtl/pc_sequencer.sv
// pc_sequencer: PC / pipeline-register control FSM handling load-use stalls, memory waits and control transfers
module pc_sequencer #(
   parameter int STALL_CNT_W = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   start_i,
   input  logic [4:0]             id_rs_i,
   input  logic [4:0]             id_rt_i,
   input  logic                   ex_memread_i,
   input  logic [4:0]             ex_rt_i,
   input  logic                   branch_taken_i,
   input  logic                   jump_i,
   input  logic                   dmem_busy_i,
   output logic                   pc_hold_o,
   output logic [1:0]             pc_sel_o,
   output logic                   if_id_hold_o,
   output logic                   if_id_flush_o,
   output logic                   id_ex_bubble_o,
   output logic                   pipe_freeze_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o,
   output logic                   timeout_o
);
   localparam int WCW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RUN      = 3'd1;
   localparam logic [2:0] LU_STALL = 3'd2;
   localparam logic [2:0] MEM_WAIT = 3'd3;
   localparam logic [2:0] HALT     = 3'd4;
   logic [2:0]     state, state_nxt;
   logic [WCW-1:0] wait_cnt;
   logic           act, lu, hold, wait_hit;
   // Active states share one fresh decode; busy outranks load-use, which outranks jump over branch
   always_comb begin
      act            = state == RUN || state == LU_STALL || state == MEM_WAIT;
      lu             = ex_memread_i && ex_rt_i != 5'd0 && (ex_rt_i == id_rs_i || ex_rt_i == id_rt_i);
      hold           = dmem_busy_i || lu;
      wait_hit       = state == MEM_WAIT && dmem_busy_i && int'(wait_cnt) == MEM_TIMEOUT - 1;
      pc_hold_o      = !act || hold;
      if_id_hold_o   = !act || hold;
      pipe_freeze_o  = act && dmem_busy_i;
      id_ex_bubble_o = act && !dmem_busy_i && lu;
      if_id_flush_o  = act && !hold && (jump_i || branch_taken_i);
      pc_sel_o       = (!act || hold) ? 2'b00 : jump_i ? 2'b10 : branch_taken_i ? 2'b01 : 2'b00;
      state_nxt      = (state == HALT || wait_hit) ? HALT :
                       !act                         ? (start_i ? RUN : IDLE) :
                       dmem_busy_i                  ? MEM_WAIT :
                       (state == RUN && lu)         ? LU_STALL :
                       start_i                      ? RUN : IDLE;
   end
   // State, wait timer, sticky timeout and saturating stall counter
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         timeout_o   <= 1'b0;
         stall_cnt_o <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= (state == MEM_WAIT && dmem_busy_i) ? wait_cnt + 1'b1 : '0;
         if (wait_hit) timeout_o <= 1'b1;
         if (act && pc_hold_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of pc_sequencer with a 2-bit stall counter and a 4-cycle memory timeout
module tb_pc_sequencer;
   logic       clk_i = 1'b0;
   logic       rst_n_i, start_i, ex_memread_i, branch_taken_i, jump_i, dmem_busy_i;
   logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
   logic       pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_bubble_o, pipe_freeze_o, timeout_o;
   logic [1:0] pc_sel_o;
   logic [1:0] stall_cnt_o;
   int         n_cmp = 0;
   int         n_bad = 0;

   pc_sequencer #(.STALL_CNT_W(2), .MEM_TIMEOUT(4)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
      .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
      .branch_taken_i(branch_taken_i), .jump_i(jump_i), .dmem_busy_i(dmem_busy_i),
      .pc_hold_o(pc_hold_o), .pc_sel_o(pc_sel_o),
      .if_id_hold_o(if_id_hold_o), .if_id_flush_o(if_id_flush_o),
      .id_ex_bubble_o(id_ex_bubble_o), .pipe_freeze_o(pipe_freeze_o),
      .stall_cnt_o(stall_cnt_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // packs hold, if_id_hold, flush, bubble, freeze, pc_sel into one vector
   function automatic logic [31:0] ctl();
      return {26'd0, pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_bubble_o, pipe_freeze_o, pc_sel_o == 2'b11};
   endfunction

   task automatic clr();
      ex_memread_i = 1'b0; ex_rt_i = 5'd0; id_rs_i = 5'd0; id_rt_i = 5'd0;
      branch_taken_i = 1'b0; jump_i = 1'b0; dmem_busy_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0;
      tick();
      rst_n_i = 1'b1;
      #1;
   endtask

   initial begin
      start_i = 1'b0;
      clr();
      rst_n_i = 1'b0;
      #12;
      chk("rst_ctl", ctl(), 32'b110000);
      chk("rst_sel", pc_sel_o, 2'b00);
      chk("rst_cnt", stall_cnt_o, 2'd0);
      chk("rst_to", timeout_o, 1'b0);
      rst_n_i = 1'b1;
      tick();
      chk("idle_ctl", ctl(), 32'b110000);
      start_i = 1'b1;
      tick();
      chk("run_ctl", ctl(), 32'b000000);
      chk("run_sel", pc_sel_o, 2'b00);
      jump_i = 1'b1; branch_taken_i = 1'b1; #1;
      chk("jb_sel", pc_sel_o, 2'b10);
      chk("jb_ctl", ctl(), 32'b001000);
      jump_i = 1'b0; #1;
      chk("br_sel", pc_sel_o, 2'b01);
      chk("br_ctl", ctl(), 32'b001000);
      branch_taken_i = 1'b0;
      ex_memread_i = 1'b1; ex_rt_i = 5'd5; id_rt_i = 5'd5; id_rs_i = 5'd1; #1;
      chk("lu_ctl", ctl(), 32'b110100);
      jump_i = 1'b1; #1;
      chk("lu_jsel", pc_sel_o, 2'b00);
      jump_i = 1'b0;
      tick();
      clr(); #1;
      chk("lus_ctl", ctl(), 32'b000000);
      chk("lus_cnt", stall_cnt_o, 2'd1);
      tick();
      chk("lu_back_ctl", ctl(), 32'b000000);
      chk("lu_back_cnt", stall_cnt_o, 2'd1);
      ex_memread_i = 1'b1; ex_rt_i = 5'd0; id_rs_i = 5'd0; #1;
      chk("r0_ctl", ctl(), 32'b000000);
      ex_rt_i = 5'd7; id_rs_i = 5'd7; id_rt_i = 5'd3; #1;
      chk("rs_lu_ctl", ctl(), 32'b110100);
      clr();
      dmem_busy_i = 1'b1; branch_taken_i = 1'b1; #1;
      chk("bz_ctl", ctl(), 32'b110010);
      chk("bz_sel", pc_sel_o, 2'b00);
      tick();
      chk("mw_ctl", ctl(), 32'b110010);
      chk("mw_sel", pc_sel_o, 2'b00);
      tick();
      dmem_busy_i = 1'b0; #1;
      chk("mw_drop_sel", pc_sel_o, 2'b01);
      chk("mw_drop_ctl", ctl(), 32'b001000);
      tick();
      branch_taken_i = 1'b0; #1;
      chk("mw_back_ctl", ctl(), 32'b000000);
      chk("mw_cnt_sat", stall_cnt_o, 2'd3);
      start_i = 1'b0;
      tick();
      chk("stop_ctl", ctl(), 32'b110000);
      chk("stop_cnt", stall_cnt_o, 2'd3);
      // timeout and saturation after five stall cycles
      do_reset();
      chk("rst2_cnt", stall_cnt_o, 2'd0);
      start_i = 1'b1;
      tick();
      dmem_busy_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("pre_to", timeout_o, 1'b0);
      chk("pre_to_ctl", ctl(), 32'b110010);
      tick();
      chk("to_set", timeout_o, 1'b1);
      chk("halt_ctl", ctl(), 32'b110000);
      chk("to_cnt_sat", stall_cnt_o, 2'd3);
      dmem_busy_i = 1'b0;
      tick();
      tick();
      chk("halt_stay_ctl", ctl(), 32'b110000);
      chk("halt_stay_to", timeout_o, 1'b1);
      rst_n_i = 1'b0; #1;
      chk("to_clr", timeout_o, 1'b0);
      chk("to_clr_cnt", stall_cnt_o, 2'd0);
      tick();
      rst_n_i = 1'b1;
      // asynchronous reset in the middle of a memory wait
      tick();
      chk("rs3_run", ctl(), 32'b000000);
      dmem_busy_i = 1'b1;
      tick();
      @(negedge clk_i);
      chk("mw3_ctl", ctl(), 32'b110010);
      chk("mw3_cnt", stall_cnt_o, 2'd1);
      rst_n_i = 1'b0; #1;
      chk("async_ctl", ctl(), 32'b110000);
      chk("async_cnt", stall_cnt_o, 2'd0);
      #1;
      rst_n_i = 1'b1;
      dmem_busy_i = 1'b0;
      tick();
      chk("resume_ctl", ctl(), 32'b000000);
      chk("resume_cnt", stall_cnt_o, 2'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
